// File: rtl/rv32i_load_unit.sv
// Registered load unit: region decode, one-hot word request with wait states, LB/LH/LW/LBU/LHU
// extraction. Optional feature macro MISALIGN_SPLIT_EN splits word-crossing loads in two accesses.
module rv32i_load_unit #(
    parameter logic [31:0] R0_BASE = 32'h0000_0000,
    parameter int unsigned R0_AW   = 15,
    parameter logic [31:0] R1_BASE = 32'h0000_8000,
    parameter int unsigned R1_AW   = 14,
    parameter logic [31:0] R2_BASE = 32'h0000_C000,
    parameter int unsigned R2_AW   = 13,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_addr_i,
    input  logic [2:0]  ld_funct3_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [2:0]  mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [2:0]  mem_ack_i,
    input  logic [31:0] mem_rdata0_i,
    input  logic [31:0] mem_rdata1_i,
    input  logic [31:0] mem_rdata2_i
);

    typedef enum logic [1:0] {StIdle, StReq, StReq2, StResp} state_e;

    function automatic logic region_hit(input logic [31:0] a, input logic [31:0] base,
                                        input int unsigned aw);
        return (a >> aw) == (base >> aw);
    endfunction

    // lo is the word at A, hi the word at A+4; the pair is shifted down to the addressed byte.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] lo, input logic [31:0] hi);
        logic [63:0] dw;
        dw = {hi, lo} >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{dw[7]}}, dw[7:0]};
            3'b001:  return {{16{dw[15]}}, dw[15:0]};
            3'b010:  return dw[31:0];
            3'b100:  return {24'h0, dw[7:0]};
            3'b101:  return {16'h0, dw[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    state_e      state_q;
    logic        ld_ready_q, rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_data_q, mem_addr_q;
    logic [2:0]  mem_req_q, f3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q;

    logic [31:0] word_addr, rdata_sel;
    logic [2:0]  hit, sel;
    logic        f3_ok, acc_err, ack_hit;
`ifdef MISALIGN_SPLIT_EN
    logic [2:0]  hit_next;
    logic        cross, cross_q;
    logic [31:0] word0_q;
`endif

    assign word_addr = {ld_addr_i[31:2], 2'b00};
    assign ack_hit   = |(mem_ack_i & mem_req_q);

    always_comb begin
        hit = {region_hit(ld_addr_i, R2_BASE, R2_AW), region_hit(ld_addr_i, R1_BASE, R1_AW),
               region_hit(ld_addr_i, R0_BASE, R0_AW)};
        sel = 3'b000;
        if (hit[0])      sel = 3'b001;
        else if (hit[1]) sel = 3'b010;
        else if (hit[2]) sel = 3'b100;
        f3_ok   = ld_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        acc_err = (sel == 3'b000) || !f3_ok;
`ifdef MISALIGN_SPLIT_EN
        cross = (ld_funct3_i[1:0] == 2'b01 && ld_addr_i[1:0] == 2'b11) ||
                (ld_funct3_i[1:0] == 2'b10 && ld_addr_i[1:0] != 2'b00);
        hit_next = {region_hit(word_addr + 32'd4, R2_BASE, R2_AW),
                    region_hit(word_addr + 32'd4, R1_BASE, R1_AW),
                    region_hit(word_addr + 32'd4, R0_BASE, R0_AW)};
        if (cross && ((hit_next & sel) == 3'b000)) acc_err = 1'b1;
`else
        if ((ld_funct3_i[1:0] == 2'b01 && ld_addr_i[0]) ||
            (ld_funct3_i[1:0] == 2'b10 && ld_addr_i[1:0] != 2'b00)) acc_err = 1'b1;
`endif
    end

    always_comb begin
        rdata_sel = mem_rdata2_i;
        if (mem_req_q[0])      rdata_sel = mem_rdata0_i;
        else if (mem_req_q[1]) rdata_sel = mem_rdata1_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ld_ready_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
            mem_req_q   <= 3'b000;
            mem_addr_q  <= 32'h0;
            cnt_q       <= 8'h0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
`ifdef MISALIGN_SPLIT_EN
            cross_q     <= 1'b0;
            word0_q     <= 32'h0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ld_valid_i) begin
                        ld_ready_q <= 1'b0;
                        f3_q       <= ld_funct3_i;
                        off_q      <= ld_addr_i[1:0];
                        cnt_q      <= 8'h0;
`ifdef MISALIGN_SPLIT_EN
                        cross_q    <= cross;
`endif
                        if (acc_err) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 32'h0;
                        end else begin
                            state_q    <= StReq;
                            mem_req_q  <= sel;
                            mem_addr_q <= word_addr;
                        end
                    end
                end
                StReq: begin
                    if (ack_hit) begin
`ifdef MISALIGN_SPLIT_EN
                        if (cross_q) begin
                            word0_q    <= rdata_sel;
                            mem_addr_q <= mem_addr_q + 32'd4;
                            cnt_q      <= 8'h0;
                            state_q    <= StReq2;
                        end else begin
                            mem_req_q   <= 3'b000;
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= extend(f3_q, off_q, rdata_sel, 32'h0);
                        end
`else
                        mem_req_q   <= 3'b000;
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= extend(f3_q, off_q, rdata_sel, 32'h0);
`endif
                    end else if (cnt_q == TIMEOUT - 8'd1) begin
                        mem_req_q   <= 3'b000;
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                StReq2: begin
                    if (ack_hit) begin
                        mem_req_q   <= 3'b000;
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= extend(f3_q, off_q, word0_q, rdata_sel);
                    end else if (cnt_q == TIMEOUT - 8'd1) begin
                        mem_req_q   <= 3'b000;
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
`endif
                StResp: begin
                    state_q    <= StIdle;
                    ld_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ld_ready_o  = ld_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_rv32i_load_unit.sv
// Directed self-checking bench for rv32i_load_unit (default build; MISALIGN_SPLIT_EN variant optional).
module tb_rv32i_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [2:0]  mem_req, mem_ack;
    logic [31:0] mem_addr, mem_rdata0, mem_rdata1, mem_rdata2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32i_load_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ld_valid_i  (ld_valid),
        .ld_ready_o  (ld_ready),
        .ld_addr_i   (ld_addr),
        .ld_funct3_i (ld_funct3),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .mem_rdata0_i(mem_rdata0),
        .mem_rdata1_i(mem_rdata1),
        .mem_rdata2_i(mem_rdata2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one load for a single edge; returns 1ns into the cycle after the accept edge.
    task automatic start_load(input logic [31:0] a, input logic [2:0] f3);
        ld_valid  = 1'b1;
        ld_addr   = a;
        ld_funct3 = f3;
        tick();
        ld_valid  = 1'b0;
    endtask

    task automatic do_load(input string name, input logic [31:0] a, input logic [2:0] f3,
                           input logic [2:0] req, input logic [31:0] rd, input int waits,
                           input logic [31:0] exp);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        start_load(a, f3);
        for (int i = 0; i < waits; i++) begin
            checks++;
            if ({rsp_valid, mem_req, mem_addr} !== {1'b0, req, wa}) begin
                errors++;
                $display("FAIL %s_wait%0d: got v=%b req=%b addr=%h, expected v=0 req=%b addr=%h",
                         name, i, rsp_valid, mem_req, mem_addr, req, wa);
            end
            mem_ack = ~req;
            tick();
        end
        checks++;
        if ({mem_req, mem_addr} !== {req, wa}) begin
            errors++;
            $display("FAIL %s_req: got req=%b addr=%h, expected req=%b addr=%h",
                     name, mem_req, mem_addr, req, wa);
        end
        mem_rdata0 = ~rd;
        mem_rdata1 = ~rd;
        mem_rdata2 = ~rd;
        if (req[0]) mem_rdata0 = rd;
        if (req[1]) mem_rdata1 = rd;
        if (req[2]) mem_rdata2 = rd;
        mem_ack = req;
        tick();
        mem_ack = 3'b000;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, mem_req} !== {1'b1, 1'b0, exp, 3'b000}) begin
            errors++;
            $display("FAIL %s_rsp: got v=%b err=%b data=%h req=%b, expected v=1 err=0 data=%h req=000",
                     name, rsp_valid, rsp_err, rsp_data, mem_req, exp);
        end
        tick();
        checks++;
        if ({rsp_valid, ld_ready, rsp_data} !== {1'b0, 1'b1, exp}) begin
            errors++;
            $display("FAIL %s_after: got v=%b rdy=%b data=%h, expected v=0 rdy=1 data=%h",
                     name, rsp_valid, ld_ready, rsp_data, exp);
        end
    endtask

    task automatic do_err(input string name, input logic [31:0] a, input logic [2:0] f3);
        start_load(a, f3);
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, mem_req} !== {1'b1, 1'b1, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL %s: got v=%b err=%b data=%h req=%b, expected v=1 err=1 data=0 req=000",
                     name, rsp_valid, rsp_err, rsp_data, mem_req);
        end
        tick();
        checks++;
        if ({rsp_valid, ld_ready, rsp_err} !== {1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL %s_after: got v=%b rdy=%b err=%b, expected v=0 rdy=1 err=1",
                     name, rsp_valid, ld_ready, rsp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_valid = 1'b0; ld_addr = 32'h0; ld_funct3 = 3'b000;
        mem_ack = 3'b000; mem_rdata0 = 32'h0; mem_rdata1 = 32'h0; mem_rdata2 = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({ld_ready, rsp_valid, rsp_err, rsp_data, mem_req, mem_addr} !==
            {1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset: got rdy=%b v=%b err=%b data=%h req=%b addr=%h, expected 1 0 0 0 0 0",
                     ld_ready, rsp_valid, rsp_err, rsp_data, mem_req, mem_addr);
        end
    endtask

    task automatic test_extract();
        do_load("lb_8003", 32'h0000_8003, 3'b000, 3'b010, 32'h80AB_CDEF, 0, 32'hFFFF_FF80);
        do_load("lhu_c002", 32'h0000_C002, 3'b101, 3'b100, 32'hBEEF_1234, 3, 32'h0000_BEEF);
        do_load("lh_c002", 32'h0000_C002, 3'b001, 3'b100, 32'hBEEF_1234, 1, 32'hFFFF_BEEF);
        do_load("lh_0000", 32'h0000_0000, 3'b001, 3'b001, 32'hBEEF_1234, 0, 32'h0000_1234);
        do_load("lbu_0001", 32'h0000_0001, 3'b100, 3'b001, 32'h0000_F100, 2, 32'h0000_00F1);
        do_load("lb_0002", 32'h0000_0002, 3'b000, 3'b001, 32'h007F_0000, 0, 32'h0000_007F);
        do_load("lw_7ffc", 32'h0000_7FFC, 3'b010, 3'b001, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        do_load("lw_dffc", 32'h0000_DFFC, 3'b010, 3'b100, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        do_load("lw_8004", 32'h0000_8004, 3'b010, 3'b010, 32'h0123_4567, 0, 32'h0123_4567);
    endtask

    task automatic test_errors();
        do_err("unmapped_10000", 32'h0001_0000, 3'b010);
        do_err("unmapped_e000", 32'h0000_E000, 3'b010);
        do_err("f3_011", 32'h0000_0000, 3'b011);
        do_err("f3_110", 32'h0000_0000, 3'b110);
        do_err("f3_111", 32'h0000_8000, 3'b111);
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_SPLIT_EN
        do_load("lh_8001_single", 32'h0000_8001, 3'b001, 3'b010, 32'h00CD_AB00, 0, 32'hFFFF_CDAB);
        start_load(32'h0000_8002, 3'b010);
        checks++;
        if ({mem_req, mem_addr} !== {3'b010, 32'h0000_8000}) begin
            errors++;
            $display("FAIL split_a: got req=%b addr=%h, expected 010 00008000", mem_req, mem_addr);
        end
        mem_ack = 3'b010;
        mem_rdata1 = 32'h4433_2211;
        tick();
        checks++;
        if ({rsp_valid, mem_req, mem_addr} !== {1'b0, 3'b010, 32'h0000_8004}) begin
            errors++;
            $display("FAIL split_b: got v=%b req=%b addr=%h, expected 0 010 00008004",
                     rsp_valid, mem_req, mem_addr);
        end
        mem_rdata1 = 32'h8877_6655;
        tick();
        mem_ack = 3'b000;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h6655_4433}) begin
            errors++;
            $display("FAIL split_rsp: got v=%b err=%b data=%h, expected 1 0 66554433",
                     rsp_valid, rsp_err, rsp_data);
        end
        tick();
`else
        do_err("lw_8002", 32'h0000_8002, 3'b010);
        do_err("lw_8001", 32'h0000_8001, 3'b010);
        do_err("lh_8001", 32'h0000_8001, 3'b001);
        do_err("lhu_c003", 32'h0000_C003, 3'b101);
`endif
    endtask

    task automatic test_timeout();
        int n;
        logic [2:0] req255;
        req255 = 3'b000;
        n = 1;
        start_load(32'h0000_8000, 3'b010);
        while (rsp_valid !== 1'b1 && n < 400) begin
            if (n == 255) req255 = mem_req;
            tick();
            n++;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL timeout_latency: rsp_valid seen in cycle T+%0d, expected T+256", n);
        end
        checks++;
        if ({rsp_err, rsp_data, mem_req, req255} !== {1'b1, 32'h0, 3'b000, 3'b010}) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%b data=%h req=%b req@255=%b, expected 1 0 000 010",
                     rsp_err, rsp_data, mem_req, req255);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int pulses;
        pulses = 0;
        start_load(32'h0000_8000, 3'b010);
        repeat (9) tick();
        checks++;
        if (mem_req !== 3'b010) begin
            errors++;
            $display("FAIL abort_busy: got req=%b, expected 010", mem_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req, ld_ready, rsp_valid} !== {3'b000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset: got req=%b rdy=%b v=%b, expected 000 1 0",
                     mem_req, ld_ready, rsp_valid);
        end
        repeat (20) begin
            if (rsp_valid === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_rsp: got %0d rsp_valid pulses, expected 0", pulses);
        end
        do_load("after_abort", 32'h0000_8000, 3'b010, 3'b010, 32'h1357_9BDF, 0, 32'h1357_9BDF);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [6];
        exp = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
        mem_ack = 3'b001;
        mem_rdata0 = 32'h1234_5678;
        mem_rdata1 = 32'h0;
        mem_rdata2 = 32'h0;
        ld_valid = 1'b1;
        ld_addr = 32'h0;
        ld_funct3 = 3'b010;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({rsp_valid, ld_ready} !== exp[k]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got {v,rdy}=%b%b, expected %b",
                         k + 1, rsp_valid, ld_ready, exp[k]);
            end
            if (exp[k][1]) begin
                checks++;
                if ({rsp_err, rsp_data} !== {1'b0, 32'h1234_5678}) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got err=%b data=%h, expected 0 12345678",
                             k + 1, rsp_err, rsp_data);
                end
            end
        end
        ld_valid = 1'b0;
        mem_ack = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_extract();
        test_errors();
        test_misalign();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
